updown_timer_gen: RTL and testbench
===================================

// Module: updown_timer_gen
// PURPOSE
//  Parametrised up/down tick counter with integrated prescaler, run/pause/one-shot FSM and timed buzzer.
//  Successor of the fixed 0..99 board counter: one clock domain, no derived clocks.
//  Configurable terminal value, parallel load, wrap or one-shot mode.
//  Drives the 7-seg display path (Count) and board buzzer.
// PARAMETERS
//  DIV        50_000_000  Clk cycles per count tick; legal >=1; DIV=1 gives a tick every Clk.
//  MAX        99          terminal value; legal >=1; count range 0..MAX.
//  BUZ_TICKS  3           ticks buz stays high after a terminal event; legal >=1.
//  W          $clog2(MAX+1)  derived local width of Count; not overridable.
// PORTS
//  Clk       in   1  system clock, all logic on rising edge
//  reset_n   in   1  asynchronous, active-low reset
//  start     in   1  sync level; enter/resume RUN
//  stop      in   1  sync level; pause counting
//  clear     in   1  sync; Count to start value (0 up / MAX down)
//  load      in   1  sync; Count <= load_val
//  load_val  in   W  parallel load value
//  up_down   in   1  1=count up, 0=count down
//  one_shot  in   1  1=stop at terminal, 0=wrap
//  Count     out  W  current count
//  tick      out  1  prescaler strobe, 1 Clk wide
//  running   out  1  high in RUN
//  wrap      out  1  1-Clk pulse on terminal event
//  buz       out  1  buzzer enable
// BEHAVIOUR
//  Reset (reset_n=0, async): Count=0, state IDLE, prescaler=0, tick=0, running=0, wrap=0, buz=0, buzzer timer=0.
//  Prescaler: free-runs 0..DIV-1 in all states; tick=1 in the Clk where prescaler==DIV-1; clear/load force prescaler=0.
//  FSM states: IDLE, RUN, PAUSED, DONE. running = (state==RUN).
//  Per-Clk priority: clear > load > stop > start > tick.
//   clear: Count <= up_down?0:MAX. State is unchanged except DONE->IDLE. Buzzer timer=0.
//   load: Count <= (load_val>MAX)?MAX:load_val (saturate). State is unchanged except DONE->IDLE.
//   stop: RUN->PAUSED; other states hold. stop wins over start in the same Clk.
//   start: IDLE/PAUSED->RUN. DONE->RUN with Count reloaded to start value (0 up / MAX down).
//   tick in RUN, up_down=1: Count<MAX -> Count+1; Count==MAX -> terminal.
//   tick in RUN, up_down=0: Count>0 -> Count-1; Count==0 -> terminal.
//   terminal, one_shot=0: Count wraps (MAX->0 up, 0->MAX down); state stays RUN.
//   terminal, one_shot=1: Count holds; state ->DONE.
//   every terminal: wrap=1 for that Clk; buzzer timer <= BUZ_TICKS.
//  Count updates one Clk after the qualifying tick edge; no other latency.
//  Buzzer timer: decrements on every tick while nonzero, in any state. A terminal event reloads it (does not add).
//   buz = (timer!=0), registered.
//  up_down/one_shot are sampled only on tick. Direction change mid-run affects the next tick. No ticks are lost.
//  Ticks in IDLE/PAUSED/DONE do not change Count.
//  Count never exceeds MAX.
//  Reset mid-operation: immediate return to reset values, regardless of state or pending events.
// TESTING  (DIV=4, MAX=9, BUZ_TICKS=2 unless noted)
//  1. reset, start, up_down=1, one_shot=0, 40 Clk -> Count 0..9 then 0.
//     wrap pulse 1 Clk at 9->0; buz high for exactly 2 ticks (8 Clk).
//  2. up_down=0, one_shot=1, load load_val=3, start -> Count 3,2,1,0; state DONE, running=0, Count holds 0.
//     Then start -> Count=9, RUN.
//  3. Count=5 in RUN, assert stop and start together -> PAUSED, Count holds 5.
//     Release stop -> resumes at 6 on next tick.
//  4. load with load_val=12 (W=4) -> Count=9 (saturated), prescaler restarts, first tick 4 Clk later.
//  5. Count=7 RUN, clear and load same Clk (up) -> Count=0.
//     reset_n low mid-buzz -> buz=0, Count=0, IDLE asynchronously.
//  6. DIV=1, MAX=1, up -> tick every Clk; Count toggles 0,1,0; wrap every 2nd Clk; buz stays high continuously.

Source files
------------

// File: rtl/updown_timer_gen.sv
// updown_timer_gen: prescaled up/down tick counter with run/pause/one-shot control and timed buzzer
module updown_timer_gen #(
  parameter int DIV = 50_000_000,
  parameter int MAX = 99,
  parameter int BUZ_TICKS = 3,
  localparam int W = $clog2(MAX + 1)
) (
  input  logic         Clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         up_down,
  input  logic         one_shot,
  output logic [W-1:0] Count,
  output logic         tick,
  output logic         running,
  output logic         wrap,
  output logic         buz
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int TW = $clog2(BUZ_TICKS + 1);
  localparam logic [W-1:0] CMAX = W'(MAX);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [TW-1:0] TBUZ = TW'(BUZ_TICKS);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0] cnt_q, cnt_d, start_val;
  logic [TW-1:0] timer_q, timer_d;
  logic tick_q, tick_d, wrap_q, wrap_d, buz_q, buz_d;
  always_comb begin
    presc_d = (clear || load || presc_q == PMAX) ? '0 : presc_q + PW'(1);
    tick_d = presc_d == PMAX;
    start_val = up_down ? '0 : CMAX;
    state_d = state_q;
    cnt_d = cnt_q;
    wrap_d = 1'b0;
    timer_d = (tick_q && timer_q != '0) ? timer_q - TW'(1) : timer_q;
    if (clear) begin
      cnt_d = start_val;
      timer_d = '0;
      state_d = state_q == DONE ? IDLE : state_q;
    end else if (load) begin
      cnt_d = load_val > CMAX ? CMAX : load_val;
      state_d = state_q == DONE ? IDLE : state_q;
    end else if (stop) begin
      state_d = state_q == RUN ? PAUSED : state_q;
    end else if (start && state_q != RUN) begin
      state_d = RUN;
      cnt_d = state_q == DONE ? start_val : cnt_q;
    end else if (tick_q && state_q == RUN) begin
      // Terminal: reload the buzzer, then either wrap to the start value or park in DONE
      if (up_down ? cnt_q == CMAX : cnt_q == '0) begin
        wrap_d = 1'b1;
        timer_d = TBUZ;
        state_d = one_shot ? DONE : RUN;
        cnt_d = one_shot ? cnt_q : start_val;
      end else begin
        cnt_d = up_down ? cnt_q + W'(1) : cnt_q - W'(1);
      end
    end
    buz_d = timer_d != '0;
  end
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      cnt_q <= '0;
      timer_q <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      buz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q <= cnt_d;
      timer_q <= timer_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      buz_q <= buz_d;
    end
  end
  assign Count = cnt_q;
  assign tick = tick_q;
  assign running = state_q == RUN;
  assign wrap = wrap_q;
  assign buz = buz_q;
endmodule

// File: tb/tb_updown_timer_gen.sv
// tb_updown_timer_gen: directed table and sequence checks of updown_timer_gen (DIV=4/MAX=9 and DIV=1/MAX=1)
module tb_updown_timer_gen;
  logic Clk = 1'b0, reset_n = 1'b0;
  logic start, stop, clear, load, up_down, one_shot;
  logic [3:0] load_val, Count;
  logic tick, running, wrap, buz;
  logic start6, up_down6, zero6;
  logic [0:0] load_val6, Count6;
  logic tick6, running6, wrap6, buz6;
  int checks = 0, errors = 0, e = 0;
  typedef struct {
    logic st, sp, ud, os;
    logic [3:0] cnt;
    logic tk, run, wr, bz;
  } vec_t;
  vec_t tbl[52];
  always #5 Clk = ~Clk;
  updown_timer_gen #(.DIV(4), .MAX(9), .BUZ_TICKS(2)) u_dut (
    .Clk(Clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear), .load(load),
    .load_val(load_val), .up_down(up_down), .one_shot(one_shot), .Count(Count), .tick(tick),
    .running(running), .wrap(wrap), .buz(buz)
  );
  updown_timer_gen #(.DIV(1), .MAX(1), .BUZ_TICKS(2)) u_dut6 (
    .Clk(Clk), .reset_n(reset_n), .start(start6), .stop(zero6), .clear(zero6), .load(zero6),
    .load_val(load_val6), .up_down(up_down6), .one_shot(zero6), .Count(Count6), .tick(tick6),
    .running(running6), .wrap(wrap6), .buz(buz6)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (edge %0d): got %0h expected %0h", name, e, act, exp);
    end
  endtask
  task automatic step();
    @(posedge Clk);
    #1;
    e++;
  endtask
  task automatic adv(input int n);
    while (e < n) step();
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    {start, stop, clear, load, up_down, one_shot, start6, up_down6} = '0;
    load_val = '0;
    step();
    reset_n = 1'b1;
    e = 0;
  endtask
  initial begin
    zero6 = 1'b0;
    load_val6 = '0;
    for (int n = 1; n <= 52; n++) begin
      tbl[n-1].st = 1'b1; tbl[n-1].sp = 1'b0; tbl[n-1].ud = 1'b1; tbl[n-1].os = 1'b0;
      tbl[n-1].cnt = 4'((n / 4) % 10);
      tbl[n-1].tk = n % 4 == 3;
      tbl[n-1].run = 1'b1;
      tbl[n-1].wr = n == 40;
      tbl[n-1].bz = n >= 40 && n < 48;
    end
    do_reset();
    chk("reset_state", {Count, tick, running, wrap, buz}, 8'h00);
    chk("reset_state6", {Count6, tick6, running6, wrap6, buz6}, 5'h00);
    for (int i = 0; i < 52; i++) begin
      {start, stop, up_down, one_shot} = {tbl[i].st, tbl[i].sp, tbl[i].ud, tbl[i].os};
      step();
      chk($sformatf("t1_vec%0d", i), {Count, tick, running, wrap, buz},
          {tbl[i].cnt, tbl[i].tk, tbl[i].run, tbl[i].wr, tbl[i].bz});
    end
    do_reset();
    {up_down, one_shot, load, load_val} = {1'b0, 1'b1, 1'b1, 4'd3};
    step();
    chk("t2_load", {Count, running}, {4'd3, 1'b0});
    {load, start} = 2'b01;
    step();
    start = 1'b0;
    chk("t2_run", {Count, running}, {4'd3, 1'b1});
    adv(5);  chk("t2_c2", Count, 2);
    adv(9);  chk("t2_c1", Count, 1);
    adv(13); chk("t2_c0", {Count, running}, {4'd0, 1'b1});
    adv(17); chk("t2_done", {Count, running, wrap, buz}, {4'd0, 3'b011});
    adv(21); chk("t2_hold", {Count, running, wrap, buz}, {4'd0, 3'b001});
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t2_restart", {Count, running}, {4'd9, 1'b1});
    do_reset();
    {start, up_down} = 2'b11;
    adv(20); chk("t3_c5", Count, 5);
    stop = 1'b1;
    step();  chk("t3_pause", {Count, running}, {4'd5, 1'b0});
    adv(25); chk("t3_hold", {Count, running}, {4'd5, 1'b0});
    stop = 1'b0;
    step();  chk("t3_resume", {Count, running}, {4'd5, 1'b1});
    adv(28); chk("t3_c6", Count, 6);
    do_reset();
    {start, up_down} = 2'b11;
    adv(6);
    {load, load_val} = {1'b1, 4'd12};
    step();
    load = 1'b0;
    chk("t4_sat", {Count, tick}, {4'd9, 1'b0});
    adv(9);  chk("t4_notick", tick, 0);
    adv(10); chk("t4_tick", {Count, tick}, {4'd9, 1'b1});
    adv(11); chk("t4_wrap", {Count, wrap}, {4'd0, 1'b1});
    do_reset();
    {start, up_down} = 2'b11;
    adv(28); chk("t5_c7", Count, 7);
    {clear, load, load_val} = {1'b1, 1'b1, 4'd5};
    step();
    {clear, load} = 2'b00;
    chk("t5_clear", {Count, running}, {4'd0, 1'b1});
    adv(69); chk("t5_term", {Count, wrap, buz}, {4'd0, 2'b11});
    adv(73); chk("t5_midbuz", {Count, buz}, {4'd1, 1'b1});
    #2 reset_n = 1'b0;
    #1 chk("t5_async_rst", {Count, running, wrap, buz}, 7'h00);
    do_reset();
    {start6, up_down6} = 2'b11;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (n >= 2)
        chk($sformatf("t6_edge%0d", n), {Count6, tick6, running6, wrap6, buz6},
            {1'((n - 1) % 2), 2'b11, 1'(n >= 3 && n % 2 == 1), 1'(n >= 3)});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
